// File: rtl/pack_sram_writer_if.sv
// ---------------------------------------------------------------------------
// pack_sram_writer_if
//   Bundles the packer handshake, the SRAM write port and the frame status
//   of pack_sram_writer into one interface.
//
//   Packer side : frame_start, pack_valid, pack_data  -> writer
//                 save_done                           <- writer
//   SRAM side   : sram_ready                          -> writer
//                 sram_cs, sram_we, sram_addr, sram_wdata <- writer
//   Status      : word_count, frame_done, overflow_err, checksum <- writer
//
//   modport slave  : the writer itself
//   modport master : the environment that plays both the packer and the SRAM
// ---------------------------------------------------------------------------
interface pack_sram_writer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              frame_start;
    logic              pack_valid;
    logic [DATA_W-1:0] pack_data;
    logic              sram_ready;

    logic              save_done;
    logic              sram_cs;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [ADDR_W:0]   word_count;
    logic              frame_done;
    logic              overflow_err;
    logic [DATA_W-1:0] checksum;

    modport slave (
        input  frame_start, pack_valid, pack_data, sram_ready,
        output save_done, sram_cs, sram_we, sram_addr, sram_wdata,
               word_count, frame_done, overflow_err, checksum
    );

    modport master (
        output frame_start, pack_valid, pack_data, sram_ready,
        input  save_done, sram_cs, sram_we, sram_addr, sram_wdata,
               word_count, frame_done, overflow_err, checksum
    );
endinterface

// File: rtl/pack_sram_writer.sv
// ---------------------------------------------------------------------------
// pack_sram_writer
//   Downstream stage of the 4-pixel packer. Each packed word offered on
//   pack_valid/pack_data is written to the feature SRAM at an auto-
//   incrementing word address; a one-cycle save_done pulse releases the
//   packer, and frame_done flags that DEPTH words have been stored.
//
// Parameters
//   ADDR_W  SRAM word-address width
//   DEPTH   words per frame (DEPTH <= 2**ADDR_W)
//   DATA_W  word width, equal to the packer output width
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (deassertion synchronised outside)
//   bus  pack_sram_writer_if.slave:
//          in : frame_start, pack_valid, pack_data, sram_ready
//          out: save_done, sram_cs, sram_we, sram_addr, sram_wdata,
//               word_count, frame_done, overflow_err, checksum
//
// Optional feature
//   SAVE_CHECKSUM_EN : when defined, checksum is the running sum (mod
//   2**DATA_W) of committed words; otherwise checksum is tied to 0 and no
//   adder exists.
// ---------------------------------------------------------------------------
module pack_sram_writer #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    pack_sram_writer_if.slave bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WRITE    = 3'd1;
    localparam logic [2:0] S_ACK      = 3'd2;
    localparam logic [2:0] S_WAIT_LOW = 3'd3;
    localparam logic [2:0] S_FULL     = 3'd4;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] wdata;
    logic              ovf;
    logic              commit;

    // A write lands on the edge that ends a WRITE cycle with sram_ready high.
    assign commit = (state == S_WRITE) && bus.sram_ready;

    // Strobes decode straight from the state so an async reset clears them
    // in the same instant the state register clears.
    assign bus.sram_cs      = (state == S_WRITE);
    assign bus.sram_we      = (state == S_WRITE);
    assign bus.save_done    = (state == S_ACK);
    assign bus.frame_done   = (state == S_FULL);
    assign bus.sram_addr    = addr;
    assign bus.sram_wdata   = wdata;
    assign bus.word_count   = count;
    assign bus.overflow_err = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            addr  <= '0;
            count <= '0;
            wdata <= '0;
            ovf   <= 1'b0;
        end else if (bus.frame_start) begin
            // Restart wins over everything, including an uncommitted write.
            // A still-high pack_valid belongs to the old episode, so it must
            // drop before the next capture.
            addr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= bus.pack_valid ? S_WAIT_LOW : S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.pack_valid) begin
                        wdata <= bus.pack_data;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (commit) begin
                        // When DEPTH == 2**ADDR_W the address rolls to 0
                        // here, but FULL prevents it from ever being used.
                        addr  <= addr + ADDR_W'(1);
                        count <= count + (ADDR_W + 1)'(1);
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    state <= (count == DEPTH_CNT) ? S_FULL : S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    // One word per pack_valid episode: wait for the level to
                    // fall before re-arming.
                    if (!bus.pack_valid) begin
                        state <= S_IDLE;
                    end
                end
                S_FULL: begin
                    if (bus.pack_valid) begin
                        ovf <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SAVE_CHECKSUM_EN
    logic [DATA_W-1:0] cks;

    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        // Carry out is intentionally discarded: the sum is modulo 2**DATA_W.
        return a + b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cks <= '0;
        end else if (bus.frame_start) begin
            cks <= '0;
        end else if (commit) begin
            cks <= wrap_add(cks, wdata);
        end
    end

    assign bus.checksum = cks;
`else
    assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_pack_sram_writer.sv
// ---------------------------------------------------------------------------
// tb_pack_sram_writer
//   Directed bench for pack_sram_writer with a scoreboard: each word issued
//   pushes its expected SRAM address, data and resulting word count; a
//   monitor pops and compares on every observed SRAM commit and save_done.
// ---------------------------------------------------------------------------
module tb_pack_sram_writer;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

`ifdef SAVE_CHECKSUM_EN
    localparam logic [DW-1:0] CKS_EXP = 32'h0000_0002;
`else
    localparam logic [DW-1:0] CKS_EXP = 32'h0000_0000;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW:0]   cnt;
    } exp_t;

    logic clk;
    logic rst;

    pack_sram_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pack_sram_writer #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        pending = 1'b0;
    logic [AW:0] pending_cnt = '0;
    logic        prev_sd = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples mid-cycle, consumes the scoreboard on each commit.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.sram_we && bus.sram_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {bus.sram_addr, bus.sram_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("write_addr", 64'(bus.sram_addr), 64'(e.addr));
                        check("write_data", 64'(bus.sram_wdata), 64'(e.data));
                        pending     = 1'b1;
                        pending_cnt = e.cnt;
                    end
                end
                if (bus.save_done) begin
                    check("save_done_single", 64'(prev_sd), 64'd0);
                    check("save_done_expected", 64'(pending), 64'd1);
                    check("word_count", 64'(bus.word_count), 64'(pending_cnt));
                    pending = 1'b0;
                end
                prev_sd = bus.save_done;
            end else begin
                prev_sd = 1'b0;
            end
        end
    end

    // Plays the packer (holds pack_valid until save_done) and the SRAM.
    task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int stall, input logic [AW:0] cnt);
        exp_t e;
        logic got;
        e.addr = a;
        e.data = d;
        e.cnt  = cnt;
        exp_q.push_back(e);
        bus.pack_data  = d;
        bus.pack_valid = 1'b1;
        bus.sram_ready = (stall == 0);
        tick();
        check("we_latency", 64'(bus.sram_we), 64'd1);
        bus.pack_data = ~d;
        for (int i = 0; i < stall; i++) begin
            check("bp_stable", 64'({bus.sram_cs, bus.sram_we, bus.sram_addr, bus.sram_wdata}),
                  64'({1'b1, 1'b1, a, d}));
            tick();
        end
        bus.sram_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = bus.save_done;
        end
        if (!got) check("save_done_timeout", 64'd0, 64'd1);
        bus.pack_valid = 1'b0;
        bus.sram_ready = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.pack_valid  = 1'b0;
        bus.pack_data   = '0;
        bus.sram_ready  = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              64'({bus.save_done, bus.sram_cs, bus.sram_we, bus.frame_done, bus.overflow_err,
                   bus.sram_addr, bus.word_count}), 64'd0);
        check("reset_wdata", 64'(bus.sram_wdata), 64'd0);
        check("reset_checksum", 64'(bus.checksum), 64'd0);
        rst = 1'b0;
        tick();

        // Reset asserted mid-WRITE clears outputs without waiting for an edge.
        bus.pack_data  = 32'hCAFE_F00D;
        bus.pack_valid = 1'b1;
        bus.sram_ready = 1'b0;
        tick();
        check("pre_reset_we", 64'(bus.sram_we), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({bus.save_done, bus.sram_cs, bus.sram_we, bus.sram_addr, bus.word_count}), 64'd0);
        check("async_reset_wdata", 64'(bus.sram_wdata), 64'd0);
        bus.pack_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single word, then a backpressured word.
        send_word(10'd0, 32'hDDCC_BBAA, 0, 11'd1);
        check("count_after_single", 64'(bus.word_count), 64'd1);
        send_word(10'd1, 32'h1234_5678, 5, 11'd2);

        // Fill the frame.
        send_word(10'd2, 32'hA5A5_A5A5, 0, 11'd3);
        send_word(10'd3, 32'h5A5A_5A5A, 2, 11'd4);
        check("frame_done", 64'(bus.frame_done), 64'd1);
        check("count_full", 64'(bus.word_count), 64'd4);
        check("overflow_before", 64'(bus.overflow_err), 64'd0);

        // A fifth word is refused and flagged.
        bus.pack_data  = 32'hBAD0_BAD0;
        bus.pack_valid = 1'b1;
        bus.sram_ready = 1'b1;
        tick();
        tick();
        check("overflow_err", 64'(bus.overflow_err), 64'd1);
        check("full_no_we", 64'(bus.sram_we), 64'd0);
        check("full_frame_done", 64'(bus.frame_done), 64'd1);
        bus.sram_ready  = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("restart_flags",
              64'({bus.frame_done, bus.overflow_err, bus.word_count, bus.sram_addr}), 64'd0);
        check("restart_checksum", 64'(bus.checksum), 64'd0);
        bus.pack_valid = 1'b0;
        tick();
        tick();
        send_word(10'd0, 32'h0BAD_CAFE, 0, 11'd1);

        // Abort an uncommitted write.
        bus.pack_data  = 32'h7777_7777;
        bus.pack_valid = 1'b1;
        bus.sram_ready = 1'b0;
        tick();
        tick();
        check("abort_in_write", 64'(bus.sram_we), 64'd1);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("abort_we_drop", 64'(bus.sram_we), 64'd0);
        check("abort_count", 64'(bus.word_count), 64'd0);
        bus.pack_valid = 1'b0;
        tick();
        tick();
        tick();

        // Running checksum with wrap-around.
        send_word(10'd0, 32'h0000_0001, 0, 11'd1);
        send_word(10'd1, 32'h0000_0002, 1, 11'd2);
        send_word(10'd2, 32'hFFFF_FFFF, 0, 11'd3);
        check("checksum", 64'(bus.checksum), 64'(CKS_EXP));

        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("no_pending_done", 64'(pending), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
